// File: rtl/dmac_pkg.sv
// Shared types and constants for the multi-channel DMA controller.
package dmac_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StRead,
    StWrite,
    StNext,
    StDone
  } dmac_state_e;

  localparam logic [1:0] RegAddr  = 2'b00;
  localparam logic [1:0] RegCount = 2'b01;
  localparam logic [1:0] RegMode  = 2'b11;

  localparam int unsigned ModeDir   = 0;
  localparam int unsigned ModeBurst = 1;
  localparam int unsigned ModeDec   = 2;
  localparam int unsigned ModeAuto  = 3;

endpackage

// File: rtl/dmac_arbiter.sv
// Channel arbiter: eligibility vector in, one-hot grant out.
// Define ROUND_ROBIN_EN for rotating priority; otherwise channel 0 always wins.
module dmac_arbiter #(
  parameter int unsigned NCH = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [NCH-1:0] req_i,
  input  logic           take_i,
  output logic [NCH-1:0] gnt_o
);

`ifdef ROUND_ROBIN_EN
  logic [NCH-1:0] last_q;
  logic [NCH-1:0] hi_mask;
  logic [NCH-1:0] req_hi;

  // Channels above the last-served one go first; wrap to the lowest set bit otherwise.
  always_comb begin
    hi_mask = ~((last_q << 1) - NCH'(1));
    req_hi  = req_i & hi_mask;
    gnt_o   = (req_hi != '0) ? (req_hi & (~req_hi + NCH'(1)))
                             : (req_i & (~req_i + NCH'(1)));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= NCH'(1) << (NCH - 1);
    end else if (take_i) begin
      last_q <= gnt_o;
    end
  end
`else
  logic unused_arb;
  assign unused_arb = ^{clk_i, rst_i, take_i};
  assign gnt_o      = req_i & (~req_i + NCH'(1));
`endif

endmodule

// File: rtl/dmac_multi.sv
// Multi-channel DMA controller: per-channel address/count/mode, HLD/HLDA bus tenure,
// two-cycle IO<->memory transfers. ROUND_ROBIN_EN selects rotating arbitration.
module dmac_multi
  import dmac_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned AW  = 16,
  parameter int unsigned DW  = 8,
  parameter int unsigned CW  = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   HLDA,
  input  logic [NCH-1:0]         DREQ,
  input  logic                   RDY,
  input  logic                   REGW,
  input  logic [1:0]             REGSEL,
  input  logic [$clog2(NCH)-1:0] CHSEL,
  input  logic [AW-1:0]          Setup,
  input  logic [DW-1:0]          Data_in,
  output logic                   HLD,
  output logic [NCH-1:0]         DACK,
  output logic                   MEMR,
  output logic                   MEMW,
  output logic                   IOR,
  output logic                   IOW,
  output logic                   EOP,
  output logic [AW-1:0]          Addrbus,
  output logic [DW-1:0]          Data_out,
  output logic                   BUSY,
  output logic [$clog2(NCH)-1:0] ACTCH
);

  localparam int unsigned IW = $clog2(NCH);

  dmac_state_e   state_q, state_d;
  logic [AW-1:0] addr_q      [NCH];
  logic [AW-1:0] base_addr_q [NCH];
  logic [CW-1:0] cnt_q       [NCH];
  logic [CW-1:0] base_cnt_q  [NCH];
  logic [3:0]    mode_q      [NCH];
  logic [IW-1:0] act_q;
  logic [DW-1:0] data_q;

  logic [NCH-1:0] elig, gnt;
  logic [IW-1:0]  gnt_idx;
  logic [3:0]     act_mode;
  logic [AW-1:0]  act_addr;
  logic [CW-1:0]  act_cnt;
  logic           busy, take, xfer_done, last, reload, wr_ok;

  always_comb begin
    elig    = '0;
    gnt_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      elig[i] = DREQ[i] && (cnt_q[i] != '0);
      if (gnt[i]) gnt_idx = IW'(i);
    end
  end

  dmac_arbiter #(
    .NCH (NCH)
  ) u_arbiter (
    .clk_i  (CLK),
    .rst_i  (RST),
    .req_i  (elig),
    .take_i (take),
    .gnt_o  (gnt)
  );

  assign act_mode  = mode_q[act_q];
  assign act_addr  = addr_q[act_q];
  assign act_cnt   = cnt_q[act_q];
  assign busy      = (state_q == StRead) || (state_q == StWrite) || (state_q == StNext);
  assign take      = (state_q == StIdle) && (elig != '0);
  assign xfer_done = (state_q == StWrite) && HLDA && RDY;
  assign last      = (act_cnt == '0);
  assign reload    = (state_q == StNext) && last && act_mode[ModeAuto];
  // The active channel is frozen for the whole tenure; others stay programmable.
  assign wr_ok     = REGW && (32'(CHSEL) < NCH) && !(busy && (CHSEL == act_q));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (take) state_d = StReq;
      StReq:   if (HLDA) state_d = StRead;
      StRead:  if (!HLDA) state_d = StIdle; else if (RDY) state_d = StWrite;
      StWrite: if (!HLDA) state_d = StIdle; else if (RDY) state_d = StNext;
      StNext: begin
        if (last || !act_mode[ModeBurst] || !DREQ[act_q]) state_d = StDone;
        else state_d = StRead;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    HLD     = busy || (state_q == StReq);
    BUSY    = busy;
    ACTCH   = busy ? act_q : '0;
    DACK    = busy ? (NCH'(1) << act_q) : '0;
    IOR     = (state_q == StRead) && act_mode[ModeDir];
    MEMR    = (state_q == StRead) && !act_mode[ModeDir];
    MEMW    = (state_q == StWrite) && act_mode[ModeDir];
    IOW     = (state_q == StWrite) && !act_mode[ModeDir];
    EOP     = (state_q == StNext) && last;
    Addrbus = ((state_q == StRead) || (state_q == StWrite)) ? act_addr : '0;
  end

  assign Data_out = data_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      act_q  <= '0;
      data_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        addr_q[i]      <= '0;
        base_addr_q[i] <= '0;
        cnt_q[i]       <= '0;
        base_cnt_q[i]  <= '0;
        mode_q[i]      <= '0;
      end
    end else begin
      if (take) act_q <= gnt_idx;
      if ((state_q == StRead) && HLDA && RDY) data_q <= Data_in;
      if (wr_ok) begin
        case (REGSEL)
          RegAddr: begin
            addr_q[CHSEL]      <= Setup;
            base_addr_q[CHSEL] <= Setup;
          end
          RegCount: begin
            cnt_q[CHSEL]      <= Setup[CW-1:0];
            base_cnt_q[CHSEL] <= Setup[CW-1:0];
          end
          RegMode: mode_q[CHSEL] <= Setup[3:0];
          default: ;
        endcase
      end
      if (xfer_done) begin
        addr_q[act_q] <= act_mode[ModeDec] ? act_addr - AW'(1) : act_addr + AW'(1);
        cnt_q[act_q]  <= act_cnt - CW'(1);
      end
      if (reload) begin
        addr_q[act_q] <= base_addr_q[act_q];
        cnt_q[act_q]  <= base_cnt_q[act_q];
      end
    end
  end

endmodule

// File: tb/tb_dmac_multi.sv
// Directed bench for dmac_multi with a transfer scoreboard and a bus memory model.
module tb_dmac_multi;

  localparam int unsigned NCH = 4;

  logic           clk = 1'b0;
  logic           rst, hlda, rdy, regw;
  logic [NCH-1:0] dreq;
  logic [1:0]     regsel, chsel, actch;
  logic [15:0]    setup, addrbus;
  logic [7:0]     data_in, data_out, dsalt;
  logic           hld, memr, memw, ior, iow, eop, busy;
  logic [NCH-1:0] dack;

  typedef struct {
    int unsigned ch;
    logic        dir;
    logic [15:0] addr;
  } xfer_t;

  xfer_t sb[$];
  xfer_t x;
  int    checks = 0;
  int    failures = 0;
  int    eop_cnt = 0, hld_rise = 0, ior_cyc = 0, wr_cnt = 0;
  logic  hld_prev = 1'b0;
  bit    hlda_follow = 1'b1;

  always #5 clk = ~clk;

  // Bus memory model: data depends on address; dsalt corrupts it during wait states.
  assign data_in = addrbus[7:0] ^ 8'hA5 ^ dsalt;

  dmac_multi #(
    .NCH (NCH),
    .AW  (16),
    .DW  (8),
    .CW  (16)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .HLDA     (hlda),
    .DREQ     (dreq),
    .RDY      (rdy),
    .REGW     (regw),
    .REGSEL   (regsel),
    .CHSEL    (chsel),
    .Setup    (setup),
    .Data_in  (data_in),
    .HLD      (hld),
    .DACK     (dack),
    .MEMR     (memr),
    .MEMW     (memw),
    .IOR      (ior),
    .IOW      (iow),
    .EOP      (eop),
    .Addrbus  (addrbus),
    .Data_out (data_out),
    .BUSY     (busy),
    .ACTCH    (actch)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (eop) eop_cnt++;
      if (hld && !hld_prev) hld_rise++;
      if (ior) ior_cyc++;
      if (memr || ior) begin
        chk("rd_pending", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          chk("rd_addr", addrbus, sb[0].addr);
          chk("rd_dir", ior, sb[0].dir);
        end
      end
      if ((memw || iow) && rdy && hlda) begin
        chk("wr_pending", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          x = sb.pop_front();
          chk("wr_addr", addrbus, x.addr);
          chk("wr_dir", memw, x.dir);
          chk("wr_data", data_out, x.addr[7:0] ^ 8'hA5);
          chk("wr_actch", actch, x.ch);
          chk("wr_dack", dack, 1 << x.ch);
          wr_cnt++;
        end
      end
    end
    hld_prev = hld;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (hlda_follow) hlda = hld;
    end
  endtask

  task automatic regwr(input int ch, input logic [1:0] sel, input logic [15:0] v);
    regw   = 1'b1;
    chsel  = ch[1:0];
    regsel = sel;
    setup  = v;
    cyc(1);
    regw   = 1'b0;
  endtask

  task automatic prog(input int ch, input logic [15:0] a, input logic [15:0] c,
                      input logic [15:0] m);
    regwr(ch, 2'b00, a);
    regwr(ch, 2'b01, c);
    regwr(ch, 2'b11, m);
  endtask

  task automatic push(input int ch, input logic dir, input logic [15:0] a);
    xfer_t e;
    e.ch   = ch;
    e.dir  = dir;
    e.addr = a;
    sb.push_back(e);
  endtask

  task automatic wait_eop(input string tag, input int maxc);
    int n;
    n = 0;
    while (!eop && n < maxc) begin
      cyc(1);
      n++;
    end
    chk(tag, eop, 1);
  endtask

  task automatic wait_sb(input string tag, input int maxc);
    int n;
    n = 0;
    while (sb.size() != 0 && n < maxc) begin
      cyc(1);
      n++;
    end
    chk(tag, sb.size(), 0);
  endtask

  task automatic wait_ior(input string tag, input int maxc);
    int n;
    n = 0;
    while (!ior && n < maxc) begin
      cyc(1);
      n++;
    end
    chk(tag, ior, 1);
  endtask

  initial begin
    int n;
    rst = 1'b1; hlda = 1'b0; rdy = 1'b1; regw = 1'b0; dreq = '0;
    regsel = '0; chsel = '0; setup = '0; dsalt = '0;
    #2;
    chk("reset_outs", {hld, dack, memr, memw, ior, iow, eop, addrbus, data_out, busy, actch}, 0);
    cyc(2);
    rst = 1'b0;
    dreq = 4'hF;
    cyc(3);
    chk("cnt0_never_req", hld, 0);
    dreq = '0;
    cyc(1);

    // Simultaneous requests on ch0 (two singles) and ch2 (one single).
    prog(0, 16'h0400, 16'd2, 16'b0001);
    prog(2, 16'h0500, 16'd1, 16'b0001);
    push(0, 1'b1, 16'h0400);
`ifdef ROUND_ROBIN_EN
    push(2, 1'b1, 16'h0500);
    push(0, 1'b1, 16'h0401);
`else
    push(0, 1'b1, 16'h0401);
    push(2, 1'b1, 16'h0500);
`endif
    dreq = 4'b0101;
    wait_sb("prio_xfers", 80);
    cyc(4);
    chk("prio_idle", hld, 0);
    dreq = '0;

    // Ch0 burst IO->Mem, three transfers, with latency checks.
    prog(0, 16'h008C, 16'd3, 16'b0011);
    push(0, 1'b1, 16'h008C);
    push(0, 1'b1, 16'h008D);
    push(0, 1'b1, 16'h008E);
    eop_cnt = 0;
    dreq[0] = 1'b1;
    cyc(1);
    chk("burst_hld_lat", hld, 1);
    chk("burst_no_early_strobe", ior, 0);
    cyc(1);
    chk("burst_ior_lat", ior, 1);
    wait_eop("burst_eop", 40);
    cyc(6);
    chk("burst_xfers", sb.size(), 0);
    chk("burst_eop_cnt", eop_cnt, 1);
    chk("burst_cnt0_release", hld, 0);
    dreq = '0;

    // Ch1 Mem->IO single decrement: two tenures.
    prog(1, 16'h0200, 16'd2, 16'b0100);
    push(1, 1'b0, 16'h0200);
    push(1, 1'b0, 16'h01FF);
    hld_rise = 0;
    eop_cnt = 0;
    dreq[1] = 1'b1;
    wait_sb("single_xfers", 60);
    cyc(4);
    chk("single_tenures", hld_rise, 2);
    chk("single_eop_cnt", eop_cnt, 1);
    dreq = '0;

    // Wait states in READ.
    prog(3, 16'h0700, 16'd1, 16'b0001);
    push(3, 1'b1, 16'h0700);
    ior_cyc = 0;
    dreq[3] = 1'b1;
    wait_ior("rdy_read_seen", 20);
    rdy = 1'b0;
    dsalt = 8'hFF;
    cyc(3);
    chk("rdy_ior_held", ior, 1);
    chk("rdy_no_write", memw, 0);
    rdy = 1'b1;
    dsalt = 8'h00;
    wait_sb("rdy_xfer", 20);
    chk("rdy_ior_cycles", ior_cyc, 4);
    dreq = '0;
    cyc(4);

    // Ch0 autoinit: two blocks from the same programming.
    prog(0, 16'h0010, 16'd2, 16'b1011);
    eop_cnt = 0;
    for (int b = 0; b < 2; b++) begin
      push(0, 1'b1, 16'h0010);
      push(0, 1'b1, 16'h0011);
      dreq[0] = 1'b1;
      wait_eop("auto_eop", 40);
      dreq[0] = 1'b0;
      cyc(4);
      chk("auto_xfers", sb.size(), 0);
      chk("auto_idle", hld, 0);
    end
    chk("auto_eop_cnt", eop_cnt, 2);

    // HLDA dropped during the second write; transfer repeats on re-grant.
    prog(0, 16'h0300, 16'd3, 16'b0011);
    push(0, 1'b1, 16'h0300);
    push(0, 1'b1, 16'h0301);
    push(0, 1'b1, 16'h0302);
    wr_cnt = 0;
    eop_cnt = 0;
    dreq[0] = 1'b1;
    n = 0;
    while (!(memw && wr_cnt == 1) && n < 40) begin
      cyc(1);
      n++;
    end
    chk("drop_in_write2", memw && wr_cnt == 1, 1);
    hlda_follow = 1'b0;
    hlda = 1'b0;
    cyc(1);
    chk("drop_strobes", {memr, memw, ior, iow, busy}, 0);
    cyc(1);
    chk("drop_rereq", hld, 1);
    cyc(2);
    chk("drop_wait_hlda", {hld, busy}, 2'b10);
    hlda_follow = 1'b1;
    wait_eop("drop_eop", 40);
    dreq = '0;
    cyc(4);
    chk("drop_xfers", sb.size(), 0);
    chk("drop_eop_cnt", eop_cnt, 1);

    // Reset in the middle of a burst.
    prog(2, 16'h0900, 16'd4, 16'b0011);
    push(2, 1'b1, 16'h0900);
    dreq[2] = 1'b1;
    wait_ior("rst_read_seen", 20);
    rst = 1'b1;
    #1;
    chk("rst_async_outs", {hld, dack, memr, memw, ior, iow, eop, addrbus, data_out, busy, actch}, 0);
    sb.delete();
    cyc(2);
    rst = 1'b0;
    cyc(4);
    chk("rst_regs_cleared", hld, 0);
    dreq = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmac_multi.md
Name: dmac_multi

Overview:
- Parametrised multi-channel successor to the single-channel DMAC: NCH independent channels, each with its own address, count and mode registers, sharing one system bus.
- Fixed-priority arbiter picks one requesting channel per bus tenure; HLD/HLDA bus handshake and two-cycle read/write transfers between IO and memory.
- Adds single vs burst mode, address increment/decrement, auto-initialise, per-channel DACK and active-channel reporting.

Parameters:
- NCH, 4, number of channels (2..8)
- AW, 16, address width
- DW, 8, data width
- CW, 16, transfer-count width

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- HLDA  in  1  hold acknowledge from CPU
- DREQ  in  NCH  per-channel DMA request, active-high, level
- RDY  in  1  memory/IO ready; 0 stretches current read/write cycle
- REGW  in  1  register write strobe
- REGSEL  in  2  00 address, 01 count, 11 mode, 10 reserved (ignored)
- CHSEL  in  $clog2(NCH)  channel targeted by REGW
- Setup  in  AW  register write data (count uses low CW bits, mode low 4)
- Data_in  in  DW  read data from IO or memory
- HLD  out  1  hold request to CPU
- DACK  out  NCH  one-hot acknowledge to the active channel
- MEMR, MEMW, IOR, IOW  out  1 each  active-high bus strobes
- EOP  out  1  one-cycle pulse at terminal count
- Addrbus  out  AW  current memory address
- Data_out  out  DW  write data (latched read data)
- BUSY  out  1  bus tenure in progress
- ACTCH  out  $clog2(NCH)  index of active channel (valid while BUSY)

Behaviour:
- Reset: all outputs 0; all address/count/mode/base registers 0; FSM in IDLE.
- Mode bits: [0] dir (1 IO->Mem, 0 Mem->IO); [1] burst (1) / single (0); [2] decrement (1) / increment (0); [3] autoinit.
- Register write on CLK edge when REGW=1; writing address/count also loads the autoinit base copy. Writes to the active channel while BUSY are ignored; other channels accept writes.
- A channel is eligible when DREQ[i]=1 and count[i]!=0. Count = number of transfers; count 0 never requested.
- FSM IDLE: any eligible channel -> REQ, HLD=1; lowest index wins, latched as ACTCH.
- REQ: wait for HLDA=1 -> READ; BUSY=1, DACK[ACTCH]=1.
- READ: IOR (dir=1) or MEMR (dir=0) high; Addrbus=address[ACTCH]; if RDY=1, latch Data_in -> WRITE, else stay.
- WRITE: MEMW (dir=1) or IOW (dir=0) high; Data_out=latched byte; if RDY=1: address +/-1 (wraps mod 2^AW), count-1 -> NEXT, else stay.
- NEXT: if count reached 0: EOP=1 for exactly this cycle; autoinit reloads address/count from base, otherwise the channel stays idle at count 0; -> DONE. Else burst and DREQ[ACTCH]=1 -> READ; else -> DONE.
- DONE: HLD, BUSY, DACK drop; -> IDLE. One idle cycle always separates tenures, so other channels are re-arbitrated.
- HLDA deasserted in READ/WRITE: strobes drop next cycle, -> IDLE with address/count unchanged; the interrupted transfer restarts.
- DREQ drop mid-burst: the current transfer completes, then DONE.
- RST mid-operation: immediate return to reset state; strobes drop asynchronously.
- Latency: DREQ to HLD 1 cycle; HLDA to first strobe 1 cycle; 2 cycles per transfer when RDY=1.

Optional Feature:
- ROUND_ROBIN_EN defined: rotating priority; the last-served channel becomes lowest priority at the next arbitration.
- Undefined: fixed priority, channel 0 highest.

Decomposition:
- Package dmac_pkg: FSM state enum (IDLE, REQ, READ, WRITE, NEXT, DONE), REGSEL codes, mode-bit index constants.
- One sub-module dmac_arbiter: combinational eligibility in, one-hot grant out, with pointer register under ROUND_ROBIN_EN.

Test Plan:
- Ch0: addr 0x008C, count 3, mode 0011 (IO->Mem burst), DREQ0 held, HLDA follows HLD -> three IOR/MEMW pairs at 0x008C/8D/8E; EOP on the third NEXT; HLD drops; count0=0.
- Ch1: addr 0x0200, count 2, mode 0100 (Mem->IO single, decrement) -> two tenures, each MEMR/IOW at 0x0200 then 0x01FF; HLD released between tenures.
- DREQ0 and DREQ2 raised in the same cycle, fixed priority -> ch0 served first; with ROUND_ROBIN_EN, a second simultaneous request after ch0 is served goes to ch2.
- RDY=0 for 3 cycles during READ -> IOR held 4 cycles; data latched only on the RDY=1 cycle; address unaffected.
- Ch0 autoinit, count 2 -> EOP, then address/count reload to the programmed values; a further DREQ starts a new block.
- HLDA dropped in WRITE of transfer 2 -> bus released, count still 2 of 3 remaining; on re-grant, transfer 2 repeats at the same address; RST asserted mid-burst -> all outputs 0 that cycle.
